// File: rtl/sdr_mon_pkg.sv
// Shared types and pin decode for the SDRAM command monitor.
package sdr_mon_pkg;

  // DESL, deselected and clock-disabled cycles all share the NOP code.
  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_BST = 3'd4,
    CMD_PRE = 3'd5,
    CMD_REF = 3'd6,
    CMD_MRS = 3'd7
  } cmd_e;

  typedef enum logic [3:0] {
    VIOL_NONE        = 4'd0,
    VIOL_ACT_OPEN    = 4'd1,
    VIOL_ACCESS_IDLE = 4'd2,
    VIOL_TRCD        = 4'd3,
    VIOL_TRP         = 4'd4,
    VIOL_TRFC        = 4'd5,
    VIOL_TMRD        = 4'd6,
    VIOL_BANK_OPEN   = 4'd7,
    VIOL_MODE_VALUE  = 4'd8
  } viol_e;

  typedef enum logic {
    BANK_IDLE   = 1'b0,
    BANK_ACTIVE = 1'b1
  } bank_state_e;

  function automatic cmd_e sdr_decode(
    input logic cke,
    input logic cs_n,
    input logic ras_n,
    input logic cas_n,
    input logic we_n
  );
    cmd_e cmd;
    if (!cke || cs_n) begin
      cmd = CMD_NOP;
    end else begin
      case ({ras_n, cas_n, we_n})
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_RD;
        3'b100:  cmd = CMD_WR;
        3'b110:  cmd = CMD_BST;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_MRS;
        default: cmd = CMD_NOP;
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/sdr_mon_bank.sv
// One bank of the monitor: open/closed state, latched row, tRCD/tRP timers
// and the bank-local violation flags (codes 1..4 in bits 0..3).
module sdr_mon_bank
  import sdr_mon_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int T_RCD  = 3,
  parameter int T_RP   = 3
) (
  input  logic              sdram_clk,
  input  logic              wb_rst_i,
  input  logic              bank_sel,
  input  cmd_e              cmd,
  input  logic [ADDR_W-1:0] sdr_addr,
  output logic              bank_open,
  output logic [ADDR_W-1:0] open_row,
  output logic [3:0]        bank_viol
);

  localparam int TMR_W = $clog2(((T_RCD > T_RP) ? T_RCD : T_RP) + 1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] RCD_LOAD = TMR_W'(T_RCD - 1);
  localparam logic [TMR_W-1:0] RP_LOAD  = TMR_W'(T_RP - 1);

  bank_state_e       state_r;
  bank_state_e       state_nxt_s;
  logic [TMR_W-1:0]  trcd_r;
  logic [TMR_W-1:0]  trp_r;
  logic [ADDR_W-1:0] row_r;
  logic              act_s;
  logic              acc_s;
  logic              close_s;

  // Qualify the decoded command for this bank; addr[10] selects PRE-all / auto-precharge.
  always_comb begin
    act_s   = (cmd == CMD_ACT) && bank_sel;
    acc_s   = ((cmd == CMD_RD) || (cmd == CMD_WR)) && bank_sel;
    close_s = ((cmd == CMD_PRE) && (bank_sel || sdr_addr[10])) || (acc_s && sdr_addr[10]);
  end

  // Bank next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BANK_IDLE: begin
        if (act_s) state_nxt_s = BANK_ACTIVE;
        else       state_nxt_s = BANK_IDLE;
      end
      BANK_ACTIVE: begin
        if (close_s) state_nxt_s = BANK_IDLE;
        else         state_nxt_s = BANK_ACTIVE;
      end
      default: state_nxt_s = BANK_IDLE;
    endcase
  end

  // State, row latch and the two down-counters that stop at zero.
  always_ff @(posedge sdram_clk) begin
    if (wb_rst_i) begin
      state_r <= BANK_IDLE;
      trcd_r  <= TMR_ZERO;
      trp_r   <= TMR_ZERO;
      row_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (act_s) begin
        trcd_r <= RCD_LOAD;
        row_r  <= sdr_addr;
      end else if (trcd_r != TMR_ZERO) begin
        trcd_r <= trcd_r - TMR_ONE;
      end
      if (close_s) begin
        trp_r <= RP_LOAD;
      end else if (trp_r != TMR_ZERO) begin
        trp_r <= trp_r - TMR_ONE;
      end
    end
  end

  assign bank_open    = (state_r == BANK_ACTIVE);
  assign open_row     = row_r;
  assign bank_viol[0] = act_s && (state_r == BANK_ACTIVE);
  assign bank_viol[1] = acc_s && (state_r == BANK_IDLE);
  assign bank_viol[2] = acc_s && (trcd_r != TMR_ZERO);
  assign bank_viol[3] = act_s && (trp_r != TMR_ZERO);

endmodule

// File: rtl/sdr_cmd_monitor.sv
// Passive SDRAM command monitor: decodes the command pins, tracks bank state,
// flags timing/protocol violations and counts commands.
module sdr_cmd_monitor
  import sdr_mon_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int BA_W      = 2,
  parameter int ADDR_W    = 13,
  parameter int CNT_W     = 16,
  parameter int T_RCD     = 3,
  parameter int T_RP      = 3,
  parameter int T_RFC     = 7,
  parameter int T_MRD     = 2
) (
  input  logic                        sdram_clk,
  input  logic                        wb_rst_i,
  input  logic                        sdr_cs_n,
  input  logic                        sdr_ras_n,
  input  logic                        sdr_cas_n,
  input  logic                        sdr_we_n,
  input  logic                        sdr_cke,
  input  logic [BA_W-1:0]             sdr_ba,
  input  logic [ADDR_W-1:0]           sdr_addr,
  input  logic [ADDR_W-1:0]           cfg_sdr_mode_reg,
  input  logic                        cnt_clr,
  output logic                        cmd_valid,
  output cmd_e                        cmd_code,
  output logic [NUM_BANKS-1:0]        bank_open,
  output logic [NUM_BANKS*ADDR_W-1:0] open_row,
  output logic [CNT_W-1:0]            cnt_act,
  output logic [CNT_W-1:0]            cnt_rd,
  output logic [CNT_W-1:0]            cnt_wr,
  output logic [CNT_W-1:0]            cnt_pre,
  output logic [CNT_W-1:0]            cnt_ref,
  output logic [CNT_W-1:0]            cnt_mrs,
  output logic                        viol,
  output viol_e                       viol_code,
  output logic [7:0]                  viol_sticky,
  output logic [ADDR_W-1:0]           mode_shadow
);

  localparam int TG_W = $clog2(((T_RFC > T_MRD) ? T_RFC : T_MRD) + 1);
  localparam logic [TG_W-1:0]  TG_ZERO  = {TG_W{1'b0}};
  localparam logic [TG_W-1:0]  TG_ONE   = TG_W'(1);
  localparam logic [TG_W-1:0]  RFC_LOAD = TG_W'(T_RFC - 1);
  localparam logic [TG_W-1:0]  MRD_LOAD = TG_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  cmd_e                      cmd_s;
  logic                      any_cmd_s;
  logic [NUM_BANKS-1:0][3:0] bank_viol_s;
  logic [7:0]                viol_set_s;
  viol_e                     viol_first_s;
  logic [5:0]                cnt_hit_s;
  logic [CNT_W-1:0]          cnt_r [6];
  logic [TG_W-1:0]           trfc_r;
  logic [TG_W-1:0]           tmrd_r;
  logic                      cmd_valid_r;
  cmd_e                      cmd_code_r;
  logic                      viol_r;
  viol_e                     viol_code_r;
  logic [7:0]                viol_sticky_r;
  logic [ADDR_W-1:0]         mode_shadow_r;

  assign cmd_s     = sdr_decode(sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n);
  assign any_cmd_s = (cmd_s != CMD_NOP);
  assign cnt_hit_s = {cmd_s == CMD_MRS, cmd_s == CMD_REF, cmd_s == CMD_PRE,
                      cmd_s == CMD_WR,  cmd_s == CMD_RD,  cmd_s == CMD_ACT};

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sdr_mon_bank #(
      .ADDR_W (ADDR_W),
      .T_RCD  (T_RCD),
      .T_RP   (T_RP)
    ) u_bank (
      .sdram_clk (sdram_clk),
      .wb_rst_i  (wb_rst_i),
      .bank_sel  (sdr_ba == BA_W'(b)),
      .cmd       (cmd_s),
      .sdr_addr  (sdr_addr),
      .bank_open (bank_open[b]),
      .open_row  (open_row[b*ADDR_W +: ADDR_W]),
      .bank_viol (bank_viol_s[b])
    );
  end

  // Gather every violation raised by the sampled command; bit i is code i+1.
  always_comb begin
    viol_set_s = 8'h00;
    for (int b = 0; b < NUM_BANKS; b++) begin
      viol_set_s[3:0] = viol_set_s[3:0] | bank_viol_s[b];
    end
    viol_set_s[4] = any_cmd_s && (trfc_r != TG_ZERO);
    viol_set_s[5] = any_cmd_s && (tmrd_r != TG_ZERO);
    viol_set_s[6] = ((cmd_s == CMD_REF) || (cmd_s == CMD_MRS)) && (|bank_open);
    viol_set_s[7] = (cmd_s == CMD_MRS) && (sdr_addr != cfg_sdr_mode_reg);
  end

  // Lowest-numbered violation wins the reported code.
  always_comb begin
    viol_first_s = VIOL_NONE;
    for (int i = 7; i >= 0; i--) begin
      if (viol_set_s[i]) viol_first_s = viol_e'(4'(i + 1));
      else               viol_first_s = viol_first_s;
    end
  end

  // Output registers, global timers and saturating counters; clear beats increment.
  always_ff @(posedge sdram_clk) begin
    if (wb_rst_i) begin
      cmd_valid_r   <= 1'b0;
      cmd_code_r    <= CMD_NOP;
      viol_r        <= 1'b0;
      viol_code_r   <= VIOL_NONE;
      viol_sticky_r <= 8'h00;
      mode_shadow_r <= {ADDR_W{1'b0}};
      trfc_r        <= TG_ZERO;
      tmrd_r        <= TG_ZERO;
      for (int k = 0; k < 6; k++) cnt_r[k] <= CNT_ZERO;
    end else begin
      cmd_valid_r <= any_cmd_s;
      cmd_code_r  <= cmd_s;
      viol_r      <= |viol_set_s;
      if (|viol_set_s) viol_code_r <= viol_first_s;
      if (cnt_clr) viol_sticky_r <= 8'h00;
      else         viol_sticky_r <= viol_sticky_r | viol_set_s;
      if (cmd_s == CMD_MRS) mode_shadow_r <= sdr_addr;
      if (cmd_s == CMD_REF)        trfc_r <= RFC_LOAD;
      else if (trfc_r != TG_ZERO)  trfc_r <= trfc_r - TG_ONE;
      if (cmd_s == CMD_MRS)        tmrd_r <= MRD_LOAD;
      else if (tmrd_r != TG_ZERO)  tmrd_r <= tmrd_r - TG_ONE;
      for (int k = 0; k < 6; k++) begin
        if (cnt_clr)                                     cnt_r[k] <= CNT_ZERO;
        else if (cnt_hit_s[k] && (cnt_r[k] != CNT_MAX))  cnt_r[k] <= cnt_r[k] + CNT_ONE;
      end
    end
  end

  assign cmd_valid   = cmd_valid_r;
  assign cmd_code    = cmd_code_r;
  assign viol        = viol_r;
  assign viol_code   = viol_code_r;
  assign viol_sticky = viol_sticky_r;
  assign mode_shadow = mode_shadow_r;
  assign cnt_act     = cnt_r[0];
  assign cnt_rd      = cnt_r[1];
  assign cnt_wr      = cnt_r[2];
  assign cnt_pre     = cnt_r[3];
  assign cnt_ref     = cnt_r[4];
  assign cnt_mrs     = cnt_r[5];

endmodule
